// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the MEM stage and a debug/loader port share one single-port macro.
// The pipeline wins by default; a bounded wait forces a one-cycle debug slot that stalls the pipeline.
module dmem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [31:0]       pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_stall,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FORCE    = 2'd1;
    localparam logic [1:0] ST_DBG_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_cnt_nxt;
    logic              r_pipe_rd_pend;
    logic [DATA_W-1:0] r_pipe_rdata_hold;
    logic [DATA_W-1:0] r_dbg_rdata_hold;

    logic              w_pipe_gnt;
    logic              w_dbg_gnt;
    logic              w_force_due;
    logic              w_unused_addr_bits;

    // Only the word-address bits of the pipeline byte address reach the macro.
    assign w_unused_addr_bits = ^{pipe_addr[31:ADDR_W+2], pipe_addr[1:0]};

    // Grants are suppressed while rst is high, which keeps mem_wren low through reset.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_pipe_gnt = 1'b0;
        w_dbg_gnt  = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    w_pipe_gnt = pipe_req;
                    w_dbg_gnt  = dbg_req && !pipe_req;
                end
                ST_FORCE:    w_dbg_gnt  = 1'b1;
                ST_DBG_RESP: w_pipe_gnt = pipe_req;
                default: ;
            endcase
        end
    end

    assign w_force_due = (r_state == ST_IDLE) && dbg_req && pipe_req && (r_wait_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_dbg_gnt) begin
                    w_state_nxt = ST_DBG_RESP;
                end else if (w_force_due) begin
                    w_state_nxt = ST_FORCE;
                end
            end
            ST_FORCE:    w_state_nxt = ST_DBG_RESP;
            ST_DBG_RESP: w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // The wait counter only measures how long the current debug request has been passed over.
    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (w_dbg_gnt || !dbg_req) begin
            w_wait_cnt_nxt = '0;
        end else if ((r_state == ST_IDLE) && w_pipe_gnt && (r_wait_cnt != CNT_LAST)) begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        if (w_dbg_gnt) begin
            mem_addr = dbg_addr;
            mem_data = dbg_wdata;
            mem_wren = dbg_we;
        end else if (w_pipe_gnt) begin
            mem_addr = pipe_addr[ADDR_W+1:2];
            mem_data = pipe_wdata;
            mem_wren = pipe_we;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_wait_cnt        <= '0;
            r_pipe_rd_pend    <= 1'b0;
            r_pipe_rdata_hold <= '0;
            r_dbg_rdata_hold  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_wait_cnt     <= w_wait_cnt_nxt;
            r_pipe_rd_pend <= w_pipe_gnt && !pipe_we;
            if (r_pipe_rd_pend) begin
                r_pipe_rdata_hold <= mem_q;
            end
            if (r_state == ST_DBG_RESP) begin
                r_dbg_rdata_hold <= mem_q;
            end
        end
    end

    // Read data is forwarded straight from the macro in its valid cycle, then held.
    assign pipe_stall = (r_state == ST_FORCE);
    assign dbg_ack    = (r_state == ST_DBG_RESP);
    assign pipe_rdata = r_pipe_rd_pend ? mem_q : r_pipe_rdata_hold;
    assign dbg_rdata  = dbg_ack ? mem_q : r_dbg_rdata_hold;

    a_one_grant: assert property (@(posedge clk) disable iff (rst) !(w_pipe_gnt && w_dbg_gnt));
    a_no_write_in_reset: assert property (@(posedge clk) rst |-> !mem_wren);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural memory macro plus a due-cycle
// scoreboard for pipeline load data and debug acknowledges.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              pipe_req;
    logic              pipe_we;
    logic [31:0]       pipe_addr;
    logic [DATA_W-1:0] pipe_wdata;
    logic [DATA_W-1:0] pipe_rdata;
    logic              pipe_stall;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
        bit                chk_data;
    } exp_t;

    exp_t dbg_q[$];
    exp_t pipe_q[$];
    exp_t mon_d;
    exp_t mon_p;

    int   cyc_n    = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   wr30_cnt = 0;
    logic ram_ready = 1'b0;
    logic [DATA_W-1:0] ram [0:63];

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_req   (pipe_req),
        .pipe_we    (pipe_we),
        .pipe_addr  (pipe_addr),
        .pipe_wdata (pipe_wdata),
        .pipe_rdata (pipe_rdata),
        .pipe_stall (pipe_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
    end

    // Single-port synchronous macro: read data appears one clock after the address.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int k = 0; k < 64; k++) ram[k] <= '0;
            ram_ready <= 1'b1;
        end else if (mem_wren) begin
            ram[mem_addr] <= mem_data;
        end
        mem_q <= ram[mem_addr];
        if (mem_wren && (mem_addr == 6'd30)) wr30_cnt <= wr30_cnt + 1;
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc_n);
        end
    endtask

    always @(negedge clk) begin
        if (cyc_n > 0) begin
            if (dbg_q.size() != 0 && dbg_q[0].due == cyc_n) begin
                mon_d = dbg_q.pop_front();
                check("dbg_ack", 32'(dbg_ack), 32'd1);
                if (mon_d.chk_data) check("dbg_rdata", dbg_rdata, mon_d.data);
            end else if (dbg_ack !== 1'b0) begin
                check("dbg_ack_unexpected", 32'(dbg_ack), 32'd0);
            end
            if (pipe_q.size() != 0 && pipe_q[0].due == cyc_n) begin
                mon_p = pipe_q.pop_front();
                check("pipe_rdata", pipe_rdata, mon_p.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_pipe(input logic req, input logic we, input logic [31:0] addr, input logic [DATA_W-1:0] wdata);
        pipe_req   = req;
        pipe_we    = we;
        pipe_addr  = addr;
        pipe_wdata = wdata;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        dbg_req   = req;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wdata;
    endtask

    task automatic push_dbg(input int due, input logic [DATA_W-1:0] data, input bit chk);
        exp_t e;
        e.due = due;
        e.data = data;
        e.chk_data = chk;
        dbg_q.push_back(e);
    endtask

    task automatic push_pipe(input int due, input logic [DATA_W-1:0] data);
        exp_t e;
        e.due = due;
        e.data = data;
        e.chk_data = 1'b1;
        pipe_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with both requesters active and a pipeline write on the bus.
        rst = 1'b1;
        set_pipe(1'b1, 1'b1, 32'h20, 32'h0000_0BAD);
        set_dbg(1'b1, 1'b1, 6'd3, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            check("rst_mem_wren", 32'(mem_wren), 32'd0);
            check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
            check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
            check("rst_pipe_rdata", pipe_rdata, 32'd0);
            check("rst_dbg_rdata", dbg_rdata, 32'd0);
        end
        tick();
        rst = 1'b0;
        set_dbg(1'b0, 1'b0, 6'd0, 32'd0);
        sample();
        check("post_rst_wren", 32'(mem_wren), 32'd1);
        check("post_rst_addr", 32'(mem_addr), 32'd8);
        check("post_rst_data", mem_data, 32'h0000_0BAD);

        // Idle debug write, then a read issued while the write is being acknowledged.
        tick();
        set_pipe(1'b0, 1'b0, 32'd0, 32'd0);
        set_dbg(1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF);
        push_dbg(cyc_n + 1, 32'd0, 1'b0);
        sample();
        check("dbg_wr_wren", 32'(mem_wren), 32'd1);
        check("dbg_wr_addr", 32'(mem_addr), 32'd5);
        check("dbg_wr_data", mem_data, 32'hDEAD_BEEF);
        tick();
        set_dbg(1'b1, 1'b0, 6'd5, 32'd0);
        push_dbg(cyc_n + 2, 32'hDEAD_BEEF, 1'b1);
        sample();
        check("resp_no_dbg_grant", 32'(mem_addr), 32'd0);
        tick();
        sample();
        check("dbg_rd_addr", 32'(mem_addr), 32'd5);
        check("dbg_rd_wren", 32'(mem_wren), 32'd0);
        tick();
        set_dbg(1'b0, 1'b0, 6'd0, 32'd0);
        sample();
        tick();
        sample();
        check("dbg_rdata_hold", dbg_rdata, 32'hDEAD_BEEF);

        // Pipeline store and load of byte address 0x14 (word 5), with hold between loads.
        tick();
        set_pipe(1'b1, 1'b1, 32'h14, 32'h1234_5678);
        sample();
        check("pipe_st_addr", 32'(mem_addr), 32'd5);
        check("pipe_st_wren", 32'(mem_wren), 32'd1);
        check("pipe_st_stall", 32'(pipe_stall), 32'd0);
        tick();
        set_pipe(1'b1, 1'b0, 32'h14, 32'd0);
        push_pipe(cyc_n + 1, 32'h1234_5678);
        sample();
        check("pipe_ld_wren", 32'(mem_wren), 32'd0);
        tick();
        set_pipe(1'b1, 1'b1, 32'h14, 32'hCAFE_F00D);
        sample();
        tick();
        set_pipe(1'b0, 1'b0, 32'd0, 32'd0);
        sample();
        check("pipe_rdata_hold", pipe_rdata, 32'h1234_5678);
        tick();
        set_pipe(1'b1, 1'b0, 32'h14, 32'd0);
        push_pipe(cyc_n + 1, 32'hCAFE_F00D);
        sample();
        tick();
        set_pipe(1'b0, 1'b0, 32'd0, 32'd0);
        sample();

        // Starvation: pipeline busy every cycle, debug read of word 8 forced at cycle MAX_WAIT.
        for (int i = 0; i <= MAX_WAIT + 1; i++) begin
            tick();
            if (i == 0) begin
                set_dbg(1'b1, 1'b0, 6'd8, 32'd0);
                push_dbg(cyc_n + MAX_WAIT + 1, 32'h0000_0BAD, 1'b1);
            end
            if (i == MAX_WAIT + 1) set_dbg(1'b0, 1'b0, 6'd0, 32'd0);
            if (i < MAX_WAIT) set_pipe(1'b1, 1'b1, 32'((16 + i) * 4), 32'hA000_0000 + 32'(i));
            else              set_pipe(1'b1, 1'b1, 32'(30 * 4), 32'h5555_AAAA);
            sample();
            if (i == MAX_WAIT) begin
                check("force_stall", 32'(pipe_stall), 32'd1);
                check("force_wren", 32'(mem_wren), 32'd0);
                check("force_addr", 32'(mem_addr), 32'd8);
            end else begin
                check("starve_stall", 32'(pipe_stall), 32'd0);
                check("starve_wren", 32'(mem_wren), 32'd1);
                check("starve_addr", 32'(mem_addr), (i < MAX_WAIT) ? 32'(16 + i) : 32'd30);
            end
        end
        tick();
        set_pipe(1'b0, 1'b0, 32'd0, 32'd0);
        sample();
        check("after_force_stall", 32'(pipe_stall), 32'd0);

        // Memory contents after the stalled write, through both ports.
        tick();
        set_dbg(1'b1, 1'b0, 6'd30, 32'd0);
        push_dbg(cyc_n + 1, 32'h5555_AAAA, 1'b1);
        sample();
        tick();
        set_dbg(1'b0, 1'b0, 6'd0, 32'd0);
        sample();
        tick();
        set_pipe(1'b1, 1'b0, 32'(17 * 4), 32'd0);
        push_pipe(cyc_n + 1, 32'hA000_0001);
        sample();
        tick();
        set_pipe(1'b0, 1'b0, 32'd0, 32'd0);
        sample();
        check("held_write_once", 32'(wr30_cnt), 32'd1);

        // Reset arriving while a forced debug write is in FORCE.
        for (int i = 0; i <= MAX_WAIT; i++) begin
            tick();
            if (i == 0) set_dbg(1'b1, 1'b1, 6'd31, 32'h7777_7777);
            if (i == MAX_WAIT) rst = 1'b1;
            set_pipe(1'b1, 1'b1, 32'((40 + i) * 4), 32'hB000_0000 + 32'(i));
            sample();
            if (i == MAX_WAIT) check("rst_force_wren", 32'(mem_wren), 32'd0);
            else               check("pre_rst_stall", 32'(pipe_stall), 32'd0);
        end
        tick();
        rst = 1'b0;
        set_dbg(1'b0, 1'b0, 6'd0, 32'd0);
        set_pipe(1'b1, 1'b1, 32'(50 * 4), 32'hC000_0000);
        sample();
        check("midrst_stall", 32'(pipe_stall), 32'd0);
        check("midrst_ack", 32'(dbg_ack), 32'd0);
        check("midrst_wren", 32'(mem_wren), 32'd1);
        check("midrst_dbg_rdata", dbg_rdata, 32'd0);
        check("midrst_pipe_rdata", pipe_rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_pipe(1'b0, 1'b0, 32'd0, 32'd0);
            sample();
            check("midrst_no_ack", 32'(dbg_ack), 32'd0);
            check("midrst_no_stall", 32'(pipe_stall), 32'd0);
        end
        tick();
        set_dbg(1'b1, 1'b0, 6'd31, 32'd0);
        push_dbg(cyc_n + 1, 32'd0, 1'b1);
        sample();
        tick();
        set_dbg(1'b0, 1'b0, 6'd0, 32'd0);
        sample();
        tick();
        sample();

        check("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
        check("pipe_q_drained", 32'(pipe_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
